// File: rtl/beep_sched_if.sv
// Request/grant bundle between the application requesters and the buzzer scheduler.
interface beep_sched_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_cnt;
    logic               beep_en;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ack;
    logic               busy;

    // Application side: raises requests, watches grant/ack.
    modport master (
        output req,
        output req_cnt,
        input  beep_en,
        input  grant,
        input  ack,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  req_cnt,
        output beep_en,
        output grant,
        output ack,
        output busy
    );
endinterface

// File: rtl/beep_sched.sv
// Round-robin buzzer scheduler: grants one requester at a time and times
// its burst of beeps (ON_CYC on, OFF_CYC off per beep) on a single enable.
module beep_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ON_CYC  = 5_000_000,
    parameter int unsigned OFF_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    beep_sched_if.slave bus
);
    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned CNT_W   = 4;

    localparam logic [PH_W-1:0] ON_LOAD  = PH_W'(ON_CYC - 1);
    localparam logic [PH_W-1:0] OFF_LOAD = PH_W'(OFF_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   win_q;
    logic [CNT_W-1:0]   remain_q;
    logic [PH_W-1:0]    phase_q;
    logic               beep_en_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic               busy_q;

    logic               any_req_c;
    logic [IDX_W-1:0]   pick_c;
    logic [N_REQ-1:0]   pick_oh_c;
    logic [CNT_W-1:0]   pick_cnt_c;
    logic [IDX_W-1:0]   ptr_next_c;
    logic               win_req_c;

    // Rotating priority search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        any_req_c = 1'b0;
        pick_c    = '0;
        // Walk from farthest to nearest so the nearest set bit is written last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req[IDX_W'(idx)]) begin
                any_req_c = 1'b1;
                pick_c    = IDX_W'(idx);
            end
        end
    end

    // Winner decode: one-hot grant, its beep count and the advanced pointer.
    always_comb begin
        pick_oh_c  = N_REQ'(1) << pick_c;
        pick_cnt_c = bus.req_cnt[{pick_c, 2'b00} +: CNT_W];
        ptr_next_c = (pick_c == IDX_W'(N_REQ - 1)) ? '0 : pick_c + IDX_W'(1);
        win_req_c  = bus.req[win_q];
    end

    // Scheduler FSM with registered outputs; abort wins over phase transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            remain_q  <= '0;
            phase_q   <= '0;
            beep_en_q <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req_c) begin
                        win_q   <= pick_c;
                        grant_q <= pick_oh_c;
                        ptr_q   <= ptr_next_c;
                        busy_q  <= 1'b1;
                        if (pick_cnt_c == '0) begin
                            state_q  <= ST_DONE;
                            remain_q <= '0;
                        end else begin
                            state_q   <= ST_ON;
                            remain_q  <= pick_cnt_c;
                            phase_q   <= ON_LOAD;
                            beep_en_q <= 1'b1;
                        end
                    end
                end

                ST_ON: begin
                    if (!win_req_c) begin
                        state_q   <= ST_IDLE;
                        beep_en_q <= 1'b0;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        remain_q  <= '0;
                        phase_q   <= '0;
                    end else if (phase_q == '0) begin
                        state_q   <= ST_OFF;
                        remain_q  <= remain_q - CNT_W'(1);
                        phase_q   <= OFF_LOAD;
                        beep_en_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end

                ST_OFF: begin
                    if (!win_req_c) begin
                        state_q   <= ST_IDLE;
                        beep_en_q <= 1'b0;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        remain_q  <= '0;
                        phase_q   <= '0;
                    end else if (phase_q == '0) begin
                        if (remain_q != '0) begin
                            state_q   <= ST_ON;
                            phase_q   <= ON_LOAD;
                            beep_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            ack_q   <= grant_q;
                            phase_q <= '0;
                        end
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end

                ST_DONE: begin
                    // A zero-count grant enters with ack low; raise it one cycle later.
                    if (ack_q == '0) begin
                        ack_q <= grant_q;
                    end else begin
                        state_q <= ST_IDLE;
                        ack_q   <= '0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    beep_en_q <= 1'b0;
                    grant_q   <= '0;
                    ack_q     <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bundle from the registered outputs.
    assign bus.beep_en = beep_en_q;
    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with N_REQ=4, ON_CYC=4, OFF_CYC=3, 20 ns clock.
module tb_beep_sched;
    localparam int unsigned N_REQ = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    beep_sched_if #(.N_REQ(N_REQ)) bus ();

    beep_sched #(
        .N_REQ  (N_REQ),
        .ON_CYC (4),
        .OFF_CYC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one clock and land on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b want %b (beep,grant,ack,busy)", i, obs, 10'b0);
            end
            step();
        end
        rst = 1'b1;
        step();
        obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want %b (beep,grant,ack,busy)", obs, 10'b0);
        end
    endtask

    task automatic test_single_burst();
        logic [9:0] obs;
        logic [9:0] exp;
        logic       e_beep;
        bus.req_cnt = 16'h0020;
        bus.req     = 4'b0010;
        for (int i = 1; i <= 17; i++) begin
            step();
            e_beep = ((i >= 1) && (i <= 4)) || ((i >= 8) && (i <= 11));
            exp = {e_beep,
                   (i <= 15) ? 4'b0010 : 4'b0000,
                   (i == 15) ? 4'b0010 : 4'b0000,
                   (i <= 15) ? 1'b1 : 1'b0};
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_burst cycle %0d: got %b want %b (beep,grant,ack,busy)", i, obs, exp);
            end
            if (i == 15) bus.req = 4'b0000;
        end
    endtask

    task automatic test_zero_count();
        logic [9:0] obs;
        logic [9:0] exp;
        bus.req_cnt = 16'h0000;
        bus.req     = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = {1'b0,
                   (i <= 2) ? 4'b0100 : 4'b0000,
                   (i == 2) ? 4'b0100 : 4'b0000,
                   (i <= 2) ? 1'b1 : 1'b0};
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL zero_count cycle %0d: got %b want %b (beep,grant,ack,busy)", i, obs, exp);
            end
            if (i == 2) bus.req = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] obs;
        bus.req_cnt = 16'h0030;
        bus.req     = 4'b0010;
        step();
        step();
        obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
        n_checks++;
        if (obs !== 10'b1_0010_0000_1) begin
            n_fail++;
            $display("FAIL mid_burst_on: got %b want %b (beep,grant,ack,busy)", obs, 10'b1_0010_0000_1);
        end
        #3 rst = 1'b0;
        #1;
        obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %b want %b (beep,grant,ack,busy)", obs, 10'b0);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_held_edge: got %b want %b (beep,grant,ack,busy)", obs, 10'b0);
        end
        rst = 1'b1;
        step();
        obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %b want %b (beep,grant,ack,busy)", obs, 10'b0);
        end
    endtask

    // Expects the pointer at 0 on entry (follows the mid-burst reset).
    task automatic test_round_robin();
        logic [9:0] obs;
        logic [9:0] exp;
        logic [3:0] oh;
        int         k;
        int         o;
        bus.req_cnt = 16'h1111;
        bus.req     = 4'b1111;
        for (int i = 1; i <= 37; i++) begin
            step();
            k  = (i - 1) / 9;
            o  = (i - 1) % 9;
            oh = (k < 4) ? (4'b0001 << k) : 4'b0000;
            exp = {(k < 4) && (o < 4),
                   ((k < 4) && (o <= 7)) ? oh : 4'b0000,
                   ((k < 4) && (o == 7)) ? oh : 4'b0000,
                   (k < 4) && (o <= 7)};
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got %b want %b (beep,grant,ack,busy)", i, obs, exp);
            end
            if ((k < 4) && (o == 7)) bus.req = bus.req & ~oh;
        end
    endtask

    task automatic test_abort();
        logic [9:0] obs;
        logic [9:0] exp;
        logic       e_on;
        bus.req_cnt = 16'h3000;
        bus.req     = 4'b1000;
        for (int i = 1; i <= 20; i++) begin
            step();
            e_on = (i <= 9);
            exp = {((i <= 4) || ((i >= 8) && (i <= 9))),
                   e_on ? 4'b1000 : 4'b0000,
                   4'b0000,
                   e_on};
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort cycle %0d: got %b want %b (beep,grant,ack,busy)", i, obs, exp);
            end
            if (i == 9) bus.req = 4'b0000;
        end
    endtask

    // Pointer sits at 3 after serving requester 2, so 3 beats 0.
    task automatic test_priority();
        logic [9:0] obs;
        logic [9:0] exp [0:8];
        logic [3:0] drive [0:8];
        exp[0] = 10'b0_0100_0000_1;  drive[0] = 4'b0100;
        exp[1] = 10'b0_0100_0100_1;  drive[1] = 4'b0000;
        exp[2] = 10'b0_0000_0000_0;  drive[2] = 4'b1001;
        exp[3] = 10'b0_1000_0000_1;  drive[3] = 4'b1001;
        exp[4] = 10'b0_1000_1000_1;  drive[4] = 4'b0001;
        exp[5] = 10'b0_0000_0000_0;  drive[5] = 4'b0001;
        exp[6] = 10'b0_0001_0000_1;  drive[6] = 4'b0001;
        exp[7] = 10'b0_0001_0001_1;  drive[7] = 4'b0000;
        exp[8] = 10'b0_0000_0000_0;  drive[8] = 4'b0000;
        bus.req_cnt = 16'h0000;
        bus.req     = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            step();
            obs = {bus.beep_en, bus.grant, bus.ack, bus.busy};
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL priority step %0d: got %b want %b (beep,grant,ack,busy)", i, obs, exp[i]);
            end
            bus.req = drive[i];
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_cnt = '0;
        #5 rst = 1'b0;
        test_reset();
        test_single_burst();
        test_zero_count();
        test_reset_mid_burst();
        test_round_robin();
        test_abort();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beep_sched.md
# beep_sched

Round-robin scheduler that shares the single board buzzer between several requesters. Each requester asks for a burst of N beeps. The block grants one requester at a time, then times the on/off cadence with its own counters. It drives one enable line into the existing tone generator, which makes the audible frequency; this block only decides when the tone is on. It sits between the application logic (alarms, key-press feedback, timers) and the buzzer path.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ON_CYC, 5_000_000: clk cycles the tone is on per beep (100 ms at 50 MHz).
- OFF_CYC, 5_000_000: clk cycles of silence after each beep, including the last one.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- req  in  N_REQ  per-requester request level; held high until ack, or dropped to abort.
- req_cnt  in  4*N_REQ  beep count per requester, nibble i belongs to requester i; range 0..15.
- beep_en  out  1  enable to the tone generator, registered.
- grant  out  N_REQ  one-hot index of the requester being served, registered.
- ack  out  N_REQ  one-cycle completion pulse to the served requester, registered.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - beep_en=0, grant=0, ack=0, busy=0;
  - round-robin pointer=0;
  - all counters cleared.
- States: IDLE, ON, OFF, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit, searching upward from the pointer and wrapping past N_REQ-1 to 0.
  - Latch that requester's req_cnt into remaining.
  - Set grant to that requester's one-hot bit.
  - Set the pointer to (winner+1) mod N_REQ.
  - If remaining=0, go to DONE. Otherwise go to ON.
- ON: beep_en=1 while the phase counter counts ON_CYC cycles. On the last cycle, decrement remaining and go to OFF.
- OFF: beep_en=0 while the phase counter counts OFF_CYC cycles. On the last cycle, go to ON if remaining≠0, otherwise go to DONE.
- DONE:
  - ack[winner]=1 for exactly one cycle; grant is still held.
  - The next state is IDLE, with grant=0 and ack=0.
- Abort: if req[winner] is 0 during ON or OFF:
  - go to IDLE on the next edge, with beep_en=0 and grant=0 from that edge;
  - no ack is issued.
  - The pointer keeps the value it was given at grant.
- req_cnt is sampled only at grant. Changes during a burst are ignored.
- Requests that arrive while busy=1 wait. Nothing is queued beyond the req levels themselves.
- Phase counter width is clog2(max(ON_CYC,OFF_CYC)). The counter reloads at every state entry, so it never wraps.

## Timing
- A request high at edge E0, with the block in IDLE, is granted at E0. From E0 onward: grant valid, busy=1, beep_en=1. Grant latency is 1 cycle.
- beep_en is high for exactly ON_CYC cycles per beep and low for exactly OFF_CYC cycles between beeps. Beep period is ON_CYC+OFF_CYC cycles.
- A burst of C≥1 beeps lasts C·(ON_CYC+OFF_CYC) cycles from the grant edge. ack then rises for 1 cycle.
- C=0: ack rises on the cycle right after the grant cycle, and beep_en never goes high.
- After DONE, the block spends at least 1 IDLE cycle before the next grant. Back-to-back bursts are therefore separated by OFF_CYC+2 cycles of silence.
- A requester that still holds req high in the cycle after ack is treated as a new request. Requesters must drop req on seeing ack.
- Simultaneous requests are resolved in a single cycle using the pointer. No requester waits more than N_REQ-1 bursts.
- If rst is asserted mid-burst, beep_en drops immediately (asynchronously) and no ack is issued.

## Test plan
Parameters for all scenarios: N_REQ=4, ON_CYC=4, OFF_CYC=3, clk period 20 ns.
- Single burst: req[1]=1 with cnt=2.
  - beep_en goes 1111000 1111000.
  - ack[1] is high in cycle 15 after the grant edge.
  - grant=0010 throughout; busy drops one cycle after ack.
- Zero count: req[2]=1 with cnt=0.
  - grant=0100 for 1 cycle, then ack[2] for 1 cycle.
  - beep_en stays 0.
- Round-robin: req=1111 held constantly, each requester dropping req on its ack, all cnt=1.
  - Grants come in order 0001, 0010, 0100, 1000.
  - Each burst lasts 7 cycles followed by ack, with 1 IDLE cycle between bursts.
- Abort: req[3]=1 with cnt=3, dropped in the 2nd ON phase.
  - beep_en=0 and grant=0 from the next edge.
  - No ack[3]; the block is in IDLE.
- Reset mid-burst: pull rst low during an ON phase.
  - beep_en, grant, ack and busy all go to 0 without waiting for a clk edge.
  - After rst is released, req[0] gets the first grant (pointer=0).
- Priority after a grant: serve requester 2, then raise req[0] and req[3] together.
  - Requester 3 is granted first.
